// File: rtl/nonconsec_rep_pkg.sv
// Shared types and defaults for the non-consecutive repetition responder.
// Pure declarations; no logic, no latency, no backpressure.
package nonconsec_rep_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} ncrep_state_t;

    localparam int REP_COUNT_DEF = 3;
    localparam int TIMEOUT_DEF   = 16;

endpackage

// File: rtl/nonconsec_rep_responder_rise_detect.sv
// Rising-edge detector: one history flop plus an AND.
// Latency: rose is combinational in the edge cycle; no backpressure.
// Backpressure: none, the input is sampled every cycle.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rose
);

    logic sig_q;

    // History clears on reset, so a level held high across reset release reads as a rise.
    always_ff @(posedge clk) begin
        if (rst) sig_q <= 1'b0;
        else     sig_q <= sig;
    end

    assign rose = sig & ~sig_q;

endmodule

// File: rtl/nonconsec_rep_responder.sv
// Responder for trigger a / event b / completion c; c pulses after REP_COUNT b samples.
// Latency: c_o one cycle after the final b sample; timeout_o after TIMEOUT cycles in COUNT.
// Backpressure: none; rises while busy and b outside a transaction are ignored. Optional checks: NCREP_ASSERT_EN.
module nonconsec_rep_responder
    import nonconsec_rep_pkg::*;
#(
    parameter int REP_COUNT = REP_COUNT_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int CNT_W     = $clog2(REP_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_i,
    input  logic             b_i,
    output logic             c_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] count_o,
    output logic             timeout_o
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    ncrep_state_t     state;
    logic [TMR_W-1:0] timer;
    logic             rose;

    rise_detect u_rise (
        .clk  (clk),
        .rst  (rst),
        .sig  (a_i),
        .rose (rose)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count_o   <= '0;
            timer     <= '0;
            c_o       <= 1'b0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            c_o       <= 1'b0;
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (rose) begin
                        // The b sampled in the rise cycle belongs to this transaction.
                        count_o <= CNT_W'(b_i);
                        timer   <= '0;
                        busy_o  <= 1'b1;
                        if (b_i && REP_COUNT == 1) begin
                            state <= DONE;
                            c_o   <= 1'b1;
                        end else begin
                            state <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (b_i) count_o <= count_o + CNT_W'(1);
                    if (b_i && count_o == CNT_W'(REP_COUNT - 1)) begin
                        state <= DONE;
                        c_o   <= 1'b1;
                    end else if (TIMEOUT != 0 && timer == TMR_W'(TIMEOUT - 1)) begin
                        state     <= IDLE;
                        timeout_o <= 1'b1;
                        busy_o    <= 1'b0;
                        count_o   <= '0;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    count_o <= '0;
                end
                default: begin
                    state   <= IDLE;
                    busy_o  <= 1'b0;
                    count_o <= '0;
                end
            endcase
        end
    end

`ifdef NCREP_ASSERT_EN
    generate
        if (TIMEOUT == 0) begin : g_seq_chk
            a_rep_then_c: assert property (@(posedge clk) disable iff (rst)
                $rose(a_i) && !busy_o |-> b_i[=REP_COUNT] ##1 c_o);
        end
    endgenerate

    a_c_not_timeout: assert property (@(posedge clk) disable iff (rst) c_o |-> !timeout_o);
    a_c_single:      assert property (@(posedge clk) disable iff (rst) c_o |=> !c_o);
    a_count_bound:   assert property (@(posedge clk) disable iff (rst) count_o <= CNT_W'(REP_COUNT));
`endif

endmodule

// File: tb/tb_nonconsec_rep_responder.sv
// Directed bench for nonconsec_rep_responder: three instances (REP 3/TO 0, REP 1/TO 0, REP 3/TO 16)
// share one stimulus; each scenario task checks the instance it targets, cycle by cycle.
module tb_nonconsec_rep_responder;

    logic clk = 1'b0;
    logic rst, a, b;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       c3, busy3, to3;
    logic [1:0] cnt3;
    logic       c1, busy1, to1;
    logic [0:0] cnt1;
    logic       ct, busyt, tot;
    logic [1:0] cntt;

    always #5 clk = ~clk;

    nonconsec_rep_responder #(.REP_COUNT(3), .TIMEOUT(0)) d3 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .c_o(c3), .busy_o(busy3), .count_o(cnt3), .timeout_o(to3));

    nonconsec_rep_responder #(.REP_COUNT(1), .TIMEOUT(0)) d1 (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .c_o(c1), .busy_o(busy1), .count_o(cnt1), .timeout_o(to1));

    nonconsec_rep_responder #(.REP_COUNT(3), .TIMEOUT(16)) dt (
        .clk(clk), .rst(rst), .a_i(a), .b_i(b),
        .c_o(ct), .busy_o(busyt), .count_o(cntt), .timeout_o(tot));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; a = 1'b0; b = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; a = 1'b1; b = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({c3, busy3, cnt3, to3} !== 5'b0) begin
            n_bad++; $display("FAIL reset_d3 got %b want 00000", {c3, busy3, cnt3, to3});
        end
        n_cmp++;
        if ({ct, busyt, cntt, tot, c1, busy1, cnt1, to1} !== 9'b0) begin
            n_bad++; $display("FAIL reset_dt_d1 got %b want 0", {ct, busyt, cntt, tot, c1, busy1, cnt1, to1});
        end
        // a held high across release must be seen as a rise, with its b counted
        rst = 1'b0;
        tick();
        n_cmp++;
        if (c1 !== 1'b1) begin n_bad++; $display("FAIL reset_rise_d1_c got %b want 1", c1); end
        n_cmp++;
        if (cnt3 !== 2'd1 || busy3 !== 1'b1) begin
            n_bad++; $display("FAIL reset_rise_d3 cnt %0d busy %b want 1 1", cnt3, busy3);
        end
        a = 1'b0; b = 1'b0;
        tick(); tick();
    endtask

    task automatic test_spread;
        logic [10:0] av = 11'b00111111100;
        logic [10:0] bv = 11'b00010101000;
        logic [10:0] cv = 11'b00010000000;
        logic [10:0] yv = 11'b00011111100;
        int ce[11] = '{0, 0, 0, 1, 1, 2, 2, 3, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            a = av[i]; b = bv[i];
            tick();
            n_cmp++;
            if (c3 !== cv[i]) begin n_bad++; $display("FAIL spread_c cyc %0d got %b want %b", i, c3, cv[i]); end
            n_cmp++;
            if (busy3 !== yv[i]) begin n_bad++; $display("FAIL spread_busy cyc %0d got %b want %b", i, busy3, yv[i]); end
            n_cmp++;
            if (cnt3 !== 2'(ce[i])) begin n_bad++; $display("FAIL spread_cnt cyc %0d got %0d want %0d", i, cnt3, ce[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] av = 8'b11111100;
        logic [7:0] bv = 8'b00011100;
        logic [7:0] cv = 8'b00010000;
        int ce[8] = '{0, 0, 1, 2, 3, 0, 0, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            a = av[i]; b = bv[i];
            tick();
            n_cmp++;
            if (c3 !== cv[i]) begin n_bad++; $display("FAIL b2b_c cyc %0d got %b want %b", i, c3, cv[i]); end
            n_cmp++;
            if (cnt3 !== 2'(ce[i])) begin n_bad++; $display("FAIL b2b_cnt cyc %0d got %0d want %0d", i, cnt3, ce[i]); end
        end
    endtask

    task automatic test_single;
        logic [11:0] av = 12'b111110110000;
        logic [11:0] bv = 12'b001000010100;
        logic [11:0] cv = 12'b001000010000;
        logic [11:0] yv = 12'b001110010000;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            a = av[i]; b = bv[i];
            tick();
            n_cmp++;
            if (c1 !== cv[i]) begin n_bad++; $display("FAIL single_c cyc %0d got %b want %b", i, c1, cv[i]); end
            n_cmp++;
            if (busy1 !== yv[i]) begin n_bad++; $display("FAIL single_busy cyc %0d got %b want %b", i, busy1, yv[i]); end
            n_cmp++;
            if (cnt1 !== cv[i]) begin n_bad++; $display("FAIL single_cnt cyc %0d got %0d want %0d", i, cnt1, cv[i]); end
        end
    endtask

    task automatic test_timeout;
        logic ex_to, ex_c, ex_busy;
        int   ex_cnt;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            a = ((i >= 1 && i <= 17) || i >= 19);
            b = (i == 3 || i == 6 || i == 19 || i == 20 || i == 21);
            tick();
            ex_to   = (i == 17);
            ex_c    = (i == 21);
            ex_busy = ((i >= 1 && i <= 16) || (i >= 19 && i <= 21));
            if      (i >= 3 && i <= 5)  ex_cnt = 1;
            else if (i >= 6 && i <= 16) ex_cnt = 2;
            else if (i >= 19 && i <= 21) ex_cnt = i - 18;
            else                        ex_cnt = 0;
            n_cmp++;
            if (tot !== ex_to) begin n_bad++; $display("FAIL timeout_pulse cyc %0d got %b want %b", i, tot, ex_to); end
            n_cmp++;
            if (ct !== ex_c) begin n_bad++; $display("FAIL timeout_c cyc %0d got %b want %b", i, ct, ex_c); end
            n_cmp++;
            if (busyt !== ex_busy) begin n_bad++; $display("FAIL timeout_busy cyc %0d got %b want %b", i, busyt, ex_busy); end
            n_cmp++;
            if (cntt !== 2'(ex_cnt)) begin n_bad++; $display("FAIL timeout_cnt cyc %0d got %0d want %0d", i, cntt, ex_cnt); end
        end
    endtask

    task automatic test_ignored;
        logic [8:0] av = 9'b111101010;
        logic [8:0] bv = 9'b001110110;
        logic [8:0] cv = 9'b000010000;
        logic [8:0] yv = 9'b000011110;
        int ce[9] = '{0, 1, 2, 2, 3, 0, 0, 0, 0};
        int c_seen = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            a = av[i]; b = bv[i];
            tick();
            if (c3 === 1'b1) c_seen++;
            n_cmp++;
            if (c3 !== cv[i]) begin n_bad++; $display("FAIL ignore_c cyc %0d got %b want %b", i, c3, cv[i]); end
            n_cmp++;
            if (busy3 !== yv[i]) begin n_bad++; $display("FAIL ignore_busy cyc %0d got %b want %b", i, busy3, yv[i]); end
            n_cmp++;
            if (cnt3 !== 2'(ce[i])) begin n_bad++; $display("FAIL ignore_cnt cyc %0d got %0d want %0d", i, cnt3, ce[i]); end
        end
        n_cmp++;
        if (c_seen != 1) begin n_bad++; $display("FAIL ignore_c_pulses got %0d want 1", c_seen); end
    endtask

    task automatic test_reset_mid;
        logic [11:0] rv = 12'b000000010000;
        logic [11:0] av = 12'b111111011110;
        logic [11:0] bv = 12'b001110011100;
        logic [11:0] cv = 12'b001000000000;
        logic [11:0] yv = 12'b001111001110;
        int ce[12] = '{0, 0, 1, 2, 0, 0, 0, 1, 2, 3, 0, 0};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rst = rv[i]; a = av[i]; b = bv[i];
            tick();
            n_cmp++;
            if (c3 !== cv[i] || to3 !== 1'b0) begin
                n_bad++; $display("FAIL rstmid_c cyc %0d got c=%b to=%b want c=%b to=0", i, c3, to3, cv[i]);
            end
            n_cmp++;
            if (busy3 !== yv[i]) begin n_bad++; $display("FAIL rstmid_busy cyc %0d got %b want %b", i, busy3, yv[i]); end
            n_cmp++;
            if (cnt3 !== 2'(ce[i])) begin n_bad++; $display("FAIL rstmid_cnt cyc %0d got %0d want %0d", i, cnt3, ce[i]); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; a = 1'b0; b = 1'b0;
        test_reset();
        test_spread();
        test_back_to_back();
        test_single();
        test_timeout();
        test_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
